// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: bundles the producer handshake, the fifomem write port
// and the arbiter status outputs.
// master: environment side (producers + write-pointer logic).
// slave:  arbiter side.
interface fifo_wr_arb_if #(
    parameter int DATASIZE = 24,
    parameter int NREQ     = 4
);
    localparam int GW = $clog2(NREQ);

    logic [NREQ-1:0]          req_valid;
    logic [NREQ*DATASIZE-1:0] req_data;
    logic [NREQ-1:0]          req_last;
    logic [NREQ-1:0]          req_ready;
    logic                     wfull;
    logic [DATASIZE-1:0]      wdata;
    logic                     wclken;
    logic [GW-1:0]            grant_id;
    logic                     busy;
    logic                     timeout_err;

    modport master (
        output req_valid, req_data, req_last, wfull,
        input  req_ready, wdata, wclken, grant_id, busy, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last, wfull,
        output req_ready, wdata, wclken, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing the single fifomem write port
// between NREQ packet producers. A grant is held until the producer's last
// beat is written; wfull stalls the beat without losing or repeating it.
// Optional feature macro: FIFO_WR_ARB_TIMEOUT_EN -- releases a grant whose
// owner has stalled (req_valid low) for TIMEOUT cycles and pulses timeout_err.
module fifo_wr_arb #(
    parameter int DATASIZE = 24,
    parameter int NREQ     = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic         wclk,
    input  logic         wrst,
    fifo_wr_arb_if.slave bus
);
    localparam int GW = $clog2(NREQ);
    localparam logic [GW-1:0] LAST_IDX = GW'(NREQ - 1);

    // Out-of-range parameters leave this named block in the hierarchy,
    // which makes a bad configuration easy to spot after elaboration.
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_out_of_range
    end

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state_reg;
    logic [GW-1:0]       grant_id_reg;
    logic [GW-1:0]       rr_last_reg;
    logic                busy_reg;

    logic [DATASIZE-1:0] data_arr [NREQ];
    logic [NREQ-1:0]     ready;
    logic [GW-1:0]       winner;
    logic                found;
    logic                valid_g;
    logic                last_g;
    logic                accept;

`ifdef FIFO_WR_ARB_TIMEOUT_EN
    localparam logic [7:0] STALL_MAX = 8'(TIMEOUT - 1);
    logic [7:0] stall_cnt_reg;
    logic       timeout_err_reg;
    assign bus.timeout_err = timeout_err_reg;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // Split the flat data bus into one word per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign data_arr[gi] = bus.req_data[gi*DATASIZE +: DATASIZE];
    end

    assign valid_g = bus.req_valid[grant_id_reg];
    assign last_g  = bus.req_last[grant_id_reg];
    assign accept  = (state_reg == XFER) && valid_g && !bus.wfull;

    // Round-robin pick: first valid index above rr_last, then wrap to the
    // lowest indices (rr_last itself has lowest priority).
    always_comb begin
        winner = rr_last_reg;
        found  = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req_valid[j] && (j > int'(rr_last_reg))) begin
                found  = 1'b1;
                winner = j[GW-1:0];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req_valid[j] && (j <= int'(rr_last_reg))) begin
                found  = 1'b1;
                winner = j[GW-1:0];
            end
        end
    end

    // Only the granted requester may see ready, and only while not full.
    always_comb begin
        ready = '0;
        if (state_reg == XFER && !bus.wfull) begin
            ready[grant_id_reg] = 1'b1;
        end
    end

    assign bus.req_ready = ready;
    assign bus.wclken    = accept;
    assign bus.wdata     = data_arr[grant_id_reg];
    assign bus.grant_id  = grant_id_reg;
    assign bus.busy      = busy_reg;

    // Arbitration FSM: IDLE picks a winner, XFER holds it until the last beat.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_reg       <= IDLE;
            grant_id_reg    <= '0;
            rr_last_reg     <= LAST_IDX;
            busy_reg        <= 1'b0;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
            stall_cnt_reg   <= '0;
            timeout_err_reg <= 1'b0;
`endif
        end else begin
`ifdef FIFO_WR_ARB_TIMEOUT_EN
            timeout_err_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        grant_id_reg <= winner;
                        state_reg    <= XFER;
                        busy_reg     <= 1'b1;
                    end
                end
                XFER: begin
                    if (accept && last_g) begin
                        rr_last_reg <= grant_id_reg;
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                    end
`ifdef FIFO_WR_ARB_TIMEOUT_EN
                    // Only an absent producer counts as a stall; wfull
                    // back-pressure with valid high keeps the counter clear.
                    if (valid_g) begin
                        stall_cnt_reg <= '0;
                    end else if (stall_cnt_reg == STALL_MAX) begin
                        stall_cnt_reg   <= '0;
                        timeout_err_reg <= 1'b1;
                        rr_last_reg     <= grant_id_reg;
                        state_reg       <= IDLE;
                        busy_reg        <= 1'b0;
                    end else begin
                        stall_cnt_reg <= stall_cnt_reg + 8'd1;
                    end
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed bench for fifo_wr_arb. Producer packets are
// queued per requester; the expected write stream (requester id + word) is
// pushed to a scoreboard in the order the round-robin should serve it and
// popped on every wclken.
module tb_fifo_wr_arb;
    localparam int DATASIZE = 24;
    localparam int NREQ     = 4;
    localparam int TIMEOUT  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_wr_arb_if #(.DATASIZE(DATASIZE), .NREQ(NREQ)) bus ();

    fifo_wr_arb #(.DATASIZE(DATASIZE), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .wclk (clk),
        .wrst (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          writes   = 0;
    int          w0;
    logic [24:0] pmem [NREQ][32];
    int          phead [NREQ];
    int          ptail [NREQ];
    logic [3:0]  hold;
    logic        wfull_tb;
    logic [31:0] sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue a packet on requester id; only the first nsb beats are expected
    // to reach the memory (the rest are abandoned by the test).
    task automatic push_pkt(input int id, input int pkt, input int nbeats, input int nsb);
        logic [23:0] d;
        for (int b = 0; b < nbeats; b++) begin
            d = {id[7:0], pkt[7:0], b[7:0]};
            pmem[id][ptail[id] % 32] = {(b == nbeats - 1), d};
            ptail[id]++;
            if (b < nsb) sb.push_back({id[7:0], d});
        end
    endtask

    task automatic drive();
        logic [24:0] e;
        for (int i = 0; i < NREQ; i++) begin
            e = pmem[i][phead[i] % 32];
            bus.req_valid[i] = (phead[i] != ptail[i]) && !hold[i];
            bus.req_last[i]  = e[24];
            bus.req_data[i*DATASIZE +: DATASIZE] = e[23:0];
        end
        bus.wfull = wfull_tb;
    endtask

    // One clock: drive, sample at negedge, retire accepted beats, advance.
    task automatic tick();
        logic [31:0] e;
        drive();
        @(negedge clk);
        if (wfull_tb) begin
            check("ready_when_full", 64'(bus.req_ready), 64'd0);
            check("wclken_when_full", 64'(bus.wclken), 64'd0);
        end
        if (bus.wclken) begin
            writes++;
            if (sb.size() == 0) begin
                check("unexpected_write", 64'(bus.wclken), 64'd0);
            end else begin
                e = sb.pop_front();
                check("write_grant_id", 64'(bus.grant_id), 64'(e[31:24]));
                check("write_wdata", 64'(bus.wdata), 64'(e[23:0]));
                $display("write req=%0d wdata=%06h", bus.grant_id, bus.wdata);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) phead[i]++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        hold     = '0;
        wfull_tb = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
            for (int k = 0; k < 32; k++) pmem[i][k] = '0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_grant_id", 64'(bus.grant_id), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_wclken", 64'(bus.wclken), 64'd0);
        check("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
        rst = 1'b0;

        // Round robin across all four, then back to requester 0.
        w0 = writes;
        push_pkt(0, 1, 2, 2);
        push_pkt(1, 1, 2, 2);
        push_pkt(2, 1, 2, 2);
        push_pkt(3, 1, 2, 2);
        push_pkt(0, 2, 2, 2);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) check("rr_gap_busy", 64'(bus.busy), 64'd0);
            if (k == 4) begin
                check("rr_second_busy", 64'(bus.busy), 64'd1);
                check("rr_second_grant", 64'(bus.grant_id), 64'd1);
            end
        end
        check("rr_round_writes", 64'(writes - w0), 64'd8);
        repeat (3) tick();
        check("rr_wrap_writes", 64'(writes - w0), 64'd10);
        check("rr_sb_empty", 64'(sb.size()), 64'd0);

        // wfull back-pressure on XFER cycles 2..4.
        w0 = writes;
        push_pkt(2, 3, 3, 3);
        for (int c = 0; c < 8; c++) begin
            wfull_tb = (c >= 2 && c <= 4);
            tick();
        end
        wfull_tb = 1'b0;
        check("full_writes", 64'(writes - w0), 64'd3);
        check("full_sb_empty", 64'(sb.size()), 64'd0);

        // Packet lock: req 1 pauses mid-packet while req 3 waits.
        w0 = writes;
        hold = 4'b1000;
        push_pkt(1, 4, 3, 3);
        push_pkt(3, 4, 2, 2);
        tick();
        check("lock_grant", 64'(bus.grant_id), 64'd1);
        tick();
        hold = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("lock_req3_ready", 64'(bus.req_ready[3]), 64'd0);
            check("lock_busy", 64'(bus.busy), 64'd1);
        end
        hold = 4'b0000;
        repeat (3) tick();
        check("lock_next_grant", 64'(bus.grant_id), 64'd3);
        repeat (2) tick();
        check("lock_writes", 64'(writes - w0), 64'd5);
        check("lock_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset during the second beat of a req 0 packet.
        w0 = writes;
        push_pkt(0, 5, 3, 1);
        tick();
        tick();
        drive();
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_req_ready", 64'(bus.req_ready), 64'd0);
        check("arst_wclken", 64'(bus.wclken), 64'd0);
        check("arst_grant_id", 64'(bus.grant_id), 64'd0);
        check("arst_timeout_err", 64'(bus.timeout_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        phead[0] = ptail[0];
        push_pkt(0, 6, 1, 1);
        push_pkt(2, 6, 1, 1);
        tick();
        check("arst_first_grant", 64'(bus.grant_id), 64'd0);
        repeat (3) tick();
        check("arst_writes", 64'(writes - w0), 64'd3);
        check("arst_sb_empty", 64'(sb.size()), 64'd0);

`ifdef FIFO_WR_ARB_TIMEOUT_EN
        // Stalled owner is released after TIMEOUT stall cycles.
        hold = 4'b0100;
        push_pkt(1, 7, 2, 0);
        push_pkt(2, 7, 1, 1);
        tick();
        check("to_grant", 64'(bus.grant_id), 64'd1);
        hold = 4'b0010;
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick();
            if (c < TIMEOUT) check("to_no_pulse", 64'(bus.timeout_err), 64'd0);
        end
        check("to_pulse", 64'(bus.timeout_err), 64'd1);
        check("to_busy_low", 64'(bus.busy), 64'd0);
        tick();
        check("to_pulse_end", 64'(bus.timeout_err), 64'd0);
        check("to_next_grant", 64'(bus.grant_id), 64'd2);
        tick();
        phead[1] = ptail[1];
        hold = 4'b0000;

        // Long wfull with valid held never times out.
        push_pkt(3, 8, 1, 1);
        tick();
        wfull_tb = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            check("full_no_timeout", 64'(bus.timeout_err), 64'd0);
        end
        check("full_grant_kept", 64'(bus.busy), 64'd1);
        wfull_tb = 1'b0;
        repeat (2) tick();
        check("to_sb_empty", 64'(sb.size()), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter for the FIFO write domain. It shares the single `fifomem` write port between NREQ packet-oriented producers. It grants one producer at a time and holds the grant until that producer's last beat is written. It drives `wdata`/`wclken` into the memory and obeys `wfull` from the write-pointer logic, so no beat is lost or duplicated while the FIFO is full.

## Interface
- DATASIZE, 24, width of one data word (matches fifomem DATASIZE)
- NREQ, 4, number of requesters, legal range 2..8
- GW, $clog2(NREQ), grant index width (derived localparam, not overridable)
- TIMEOUT, 16, stall-cycle limit for the timeout feature, legal range 2..255

- wclk  input  1  write-domain clock, all state on posedge
- wrst  input  1  asynchronous active-high reset; one clock; reset is asynchronous and active-high
- req_valid  input  NREQ  per-requester beat valid
- req_data  input  NREQ*DATASIZE  per-requester word; requester i occupies bits [i*DATASIZE +: DATASIZE]
- req_last  input  NREQ  per-requester marks final beat of packet
- req_ready  output  NREQ  per-requester beat accepted when valid & ready
- wfull  input  1  FIFO full flag from write-pointer logic
- wdata  output  DATASIZE  word to fifomem
- wclken  output  1  write enable to fifomem
- grant_id  output  GW  index of current/last granted requester
- busy  output  1  high while a packet is locked (state XFER)
- timeout_err  output  1  one-cycle pulse on forced grant release; constant 0 when feature is compiled out

## Operation
- States: IDLE, XFER. Registered: state, grant_id, rr_last (last granted index), and stall_cnt (feature only).
- IDLE: if any req_valid, choose the first set bit searching (rr_last+1) mod NREQ upward with wrap. Register the winner in grant_id and go to XFER. No beat is accepted in IDLE. If no req_valid, stay in IDLE.
- XFER, with g = grant_id:
  - req_ready[g] = !wfull; all other req_ready bits are 0.
  - wclken = req_valid[g] & !wfull.
  - wdata = req_data slice g (always muxed by grant_id, including when not writing).
  - Accepted beat with req_last[g]=1: rr_last <= g and state -> IDLE.
  - Accepted beat with req_last[g]=0: stay in XFER.
  - req_valid[g] low: stay in XFER and keep the grant (packet lock).
- The arbitration decision uses req_valid sampled on the IDLE edge. A later deassert by the winner does not change the grant.
- wfull high: the write is suppressed and ready is low. The beat is retried on the first cycle wfull is low. The same beat is never written twice.
- Reset values: state=IDLE, grant_id=0, rr_last=NREQ-1 (requester 0 wins first), req_ready=0, wclken=0, busy=0, timeout_err=0, stall_cnt=0.
- Reset mid-packet: the partial packet is abandoned and arbitration restarts from requester 0. No wclken is issued during reset.

## Timing
- Arbitration latency: 1 cycle. A request arriving in IDLE gets its first accept at the earliest on the next cycle.
- Beat throughput in XFER: 1 word/cycle while req_valid[g] & !wfull.
- Inter-packet gap: exactly 1 IDLE cycle after every last beat.
- req_ready, wclken and wdata are combinational from registered state plus req_valid/req_data/wfull. There is no registered delay between accept and memory write; the write lands on the same wclk edge.
- busy equals (state==XFER), registered.

## Configuration
- Macro: FIFO_WR_ARB_TIMEOUT_EN.
- Defined:
  - In XFER, stall_cnt increments on each cycle with req_valid[g]=0, and clears on any cycle req_valid[g]=1, including cycles where wfull blocks the beat.
  - When stall_cnt reaches TIMEOUT-1 while still stalled: the grant is released (state -> IDLE, rr_last <= g), timeout_err pulses high for 1 cycle, and stall_cnt clears.
  - wfull never causes a timeout.
- Undefined: there is no counter, the grant lock is unconditional, and timeout_err is tied 0.

## Test plan
- After reset, req_valid=4'b1111, 2-beat packets with last on beat 2 -> grant order 0,1,2,3,0; exactly 8 wclken per round; 1 idle cycle between packets; wdata matches each requester's words in order.
- Only req 2 valid with 3-beat packet, wfull high on cycles 2–4 of XFER -> wclken is 0 while full; exactly 3 writes total; no word is duplicated or skipped.
- Req 1 is granted, then req 1 drops valid for 5 cycles mid-packet while req 3 is valid -> req 3 sees ready=0 throughout; req 1 resumes and completes; req 3 is granted next.
- Assert wrst for 1 cycle during the second beat of a req 0 packet -> all outputs are 0 immediately (asynchronous); the next grant goes to req 0 if valid.
- With FIFO_WR_ARB_TIMEOUT_EN and TIMEOUT=16: grant req 1, then hold req_valid[1]=0 -> timeout_err pulses after 16 stall cycles; busy falls; req 2 is granted after the IDLE cycle.
- With FIFO_WR_ARB_TIMEOUT_EN: wfull held high for 40 cycles with req_valid[g]=1 -> no timeout_err; the grant is kept.
